// File: rtl/jk_count_sequencer.sv
// Excitation sequencer for a bank of JK flip-flops: turns HOLD/UP/DOWN/LOAD commands
// into per-cell J/K drive, building a modulo-MODULUS counter out of plain JK cells.
module jk_count_sequencer #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  // One extra bit so MODULUS == 2**WIDTH compares correctly.
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   TOP_X = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] TOP_V = WIDTH'(MODULUS - 1);

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   up_t, dn_t;
  logic [WIDTH:0]     q_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          if (cmd_op == OP_LOAD || cmd_count == '0) begin
            rem_d = CNT_W'(1);
          end else begin
            rem_d = cmd_count;
          end
          state_d = RUN;
        end
      end
      RUN: begin
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ripple toggle masks: bit i flips when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    up_t    = '0;
    dn_t    = '0;
    up_t[0] = 1'b1;
    dn_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_t[i] = up_t[i-1] & q_fb[i-1];
      dn_t[i] = dn_t[i-1] & ~q_fb[i-1];
    end
  end

  assign q_x = {1'b0, q_fb};

  always_comb begin
    j = '0;
    k = '0;
    if (state_q == RUN) begin
      unique case (op_q)
        OP_HOLD: begin
          j = '0;
          k = '0;
        end
        OP_LOAD: begin
          j = data_q;
          k = ~data_q;
        end
        OP_UP: begin
          // Terminal or out-of-range counts all clear to 0.
          if (q_x >= TOP_X) begin
            j = '0;
            k = '1;
          end else begin
            j = up_t;
            k = up_t;
          end
        end
        OP_DOWN: begin
          if (q_fb == '0 || q_x >= MOD_X) begin
            j = TOP_V;
            k = ~TOP_V;
          end else begin
            j = dn_t;
            k = dn_t;
          end
        end
        default: begin
          j = '0;
          k = '0;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign done      = done_q;

endmodule

// File: tb/tb_jk_count_sequencer.sv
// Directed bench: sequencer driving a 4-cell JK bank modelled here, checked against
// hand-computed count sequences and handshake behaviour.
module tb_jk_count_sequencer;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;
  localparam int CNT_W   = 8;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             busy;
  logic             done;

  int n_checks;
  int n_fail;

  jk_count_sequencer #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .cmd_count(cmd_count),
    .q_fb     (q),
    .j        (j),
    .k        (k),
    .busy     (busy),
    .done     (done)
  );

  // JK flip-flop bank: q+ = j&~q | ~k&q, with its own async reset to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= (j & ~q) | (~k & q);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from IDLE and follow it for n steps; seq holds expected q per step,
  // nibble i = value after step edge i+1. If poke is set, a stray command is offered mid-run.
  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [3:0] data,
                        input logic [7:0] cnt, input int n, input logic [31:0] seq,
                        input logic [3:0] exp_j, input logic [3:0] exp_k, input bit poke);
    check({tag, " ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = cnt;
    tick();
    cmd_valid = 1'b0;
    check({tag, " busy0"}, 32'(busy), 32'd1);
    check({tag, " ready0"}, 32'(cmd_ready), 32'd0);
    check({tag, " j"}, 32'(j), 32'(exp_j));
    check({tag, " k"}, 32'(k), 32'(exp_k));
    if (poke) begin
      cmd_valid = 1'b1;
      cmd_op    = 2'b11;
      cmd_data  = 4'd5;
      cmd_count = 8'd1;
    end
    for (int i = 0; i < n; i++) begin
      tick();
      if (poke && i == 0) check({tag, " ready_mid"}, 32'(cmd_ready), 32'd0);
      if (poke && i == 1) cmd_valid = 1'b0;
      check({tag, " q"}, 32'(q), 32'(seq[i*4 +: 4]));
      if (i < n - 1) begin
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " done_early"}, 32'(done), 32'd0);
      end else begin
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy_end"}, 32'(busy), 32'd0);
        check({tag, " ready_end"}, 32'(cmd_ready), 32'd1);
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
    cmd_count = '0;

    #3;
    check("rst ready", 32'(cmd_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst j", 32'(j), 32'd0);
    check("rst k", 32'(k), 32'd0);
    #19 rst_n = 1'b1;
    tick();

    // 1: LOAD 7, done pulses exactly once
    do_cmd("load7", 2'b11, 4'd7, 8'd9, 1, 32'h7, 4'h7, 4'h8, 1'b0);
    tick();
    check("load7 done_once", 32'(done), 32'd0);
    check("load7 hold_q", 32'(q), 32'd7);

    // 2: UP 5 from 7 wraps through 9 -> 0; issued back-to-back into 3
    do_cmd("up5", 2'b01, 4'd0, 8'd5, 5, 32'h00021098, 4'hF, 4'hF, 1'b0);
    // 3: DOWN 4 from 2 wraps 0 -> 9, stray command ignored while busy
    do_cmd("dn4", 2'b10, 4'd0, 8'd4, 4, 32'h00008901, 4'h3, 4'h3, 1'b1);

    // 4: out-of-range 13 recovers to 0 going up
    do_cmd("load13a", 2'b11, 4'd13, 8'd0, 1, 32'hD, 4'hD, 4'h2, 1'b0);
    do_cmd("up1", 2'b01, 4'd0, 8'd1, 1, 32'h0, 4'h0, 4'hF, 1'b0);

    // 5: out-of-range 13 recovers to 9 going down, then HOLD 3
    do_cmd("load13b", 2'b11, 4'd13, 8'd0, 1, 32'hD, 4'hD, 4'h2, 1'b0);
    do_cmd("dn1", 2'b10, 4'd0, 8'd1, 1, 32'h9, 4'h9, 4'h6, 1'b0);
    do_cmd("hold3", 2'b00, 4'd0, 8'd3, 3, 32'h999, 4'h0, 4'h0, 1'b0);

    // 6: reset in the middle of a long UP
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_count = 8'd200;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("up200 q1", 32'(q), 32'd0);
    tick();
    check("up200 q2", 32'(q), 32'd1);
    check("up200 busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst j", 32'(j), 32'd0);
    check("midrst k", 32'(k), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst ready", 32'(cmd_ready), 32'd1);
    check("midrst done", 32'(done), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    check("postrst done", 32'(done), 32'd0);
    check("postrst busy", 32'(busy), 32'd0);
    do_cmd("load3", 2'b11, 4'd3, 8'd0, 1, 32'h3, 4'h3, 4'hC, 1'b0);

    // cmd_count of 0 behaves as a single step
    do_cmd("up0", 2'b01, 4'd0, 8'd0, 1, 32'h4, 4'h7, 4'h7, 1'b0);
    tick();
    check("up0 idle", 32'(busy), 32'd0);
    check("up0 q_held", 32'(q), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
